// File: rtl/ex_muldiv_pkg.sv
// Shared definitions for the EX-stage iterative multiply/divide unit:
// RISC-V M funct3 codes, scheduler state encoding and default width.
package ex_muldiv_pkg;

    localparam int XLEN_DEFAULT = 32;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic is_div(input logic [2:0] f3);
        return f3[2];
    endfunction

endpackage

// File: rtl/ex_muldiv_sched_if.sv
// Two-lane M-op request bus plus the single tagged response returned to EX/MEM.
interface ex_muldiv_sched_if
    import ex_muldiv_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
);

    logic            req_valid_0;
    logic [2:0]      req_funct3_0;
    logic [XLEN-1:0] req_a_0;
    logic [XLEN-1:0] req_b_0;
    logic [4:0]      req_rd_0;
    logic            req_ready_0;

    logic            req_valid_1;
    logic [2:0]      req_funct3_1;
    logic [XLEN-1:0] req_a_1;
    logic [XLEN-1:0] req_b_1;
    logic [4:0]      req_rd_1;
    logic            req_ready_1;

    logic            resp_valid;
    logic [XLEN-1:0] resp_data;
    logic [4:0]      resp_rd;
    logic            resp_lane;

    modport master (
        output req_valid_0, req_funct3_0, req_a_0, req_b_0, req_rd_0,
        output req_valid_1, req_funct3_1, req_a_1, req_b_1, req_rd_1,
        input  req_ready_0, req_ready_1,
        input  resp_valid, resp_data, resp_rd, resp_lane
    );

    modport slave (
        input  req_valid_0, req_funct3_0, req_a_0, req_b_0, req_rd_0,
        input  req_valid_1, req_funct3_1, req_a_1, req_b_1, req_rd_1,
        output req_ready_0, req_ready_1,
        output resp_valid, resp_data, resp_rd, resp_lane
    );

endinterface

// File: rtl/ex_muldiv_sched_rr_arbiter2.sv
// Two-way round-robin arbiter; the pointer only advances when both lanes contend.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    logic ptr;

    always_comb begin
        gnt = 2'b00;
        if (en) begin
            case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = ptr ? 2'b10 : 2'b01;
                default: gnt = 2'b00;
            endcase
        end
    end

    // A lone requester does not disturb the fairness pointer.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr <= 1'b0;
        end else if (en && (req == 2'b11)) begin
            ptr <= ~ptr;
        end
    end

endmodule

// File: rtl/ex_muldiv_sched.sv
// Shared radix-2 shift-add multiplier / restoring divider serving both issue lanes,
// returning one lane/rd-tagged result per operation.
module ex_muldiv_sched
    import ex_muldiv_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT,
    parameter int ITER = XLEN
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                flush_i,
    output logic                busy_o,
    ex_muldiv_sched_if.slave    bus
);

    localparam int CNT_W = $clog2(ITER + 1);
    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    state_t             state;
    logic [CNT_W-1:0]   count;

    logic [2:0]         op_f3;
    logic [2*XLEN-1:0]  acc;
    logic [XLEN-1:0]    opb;
    logic               neg;

    logic               en;
    logic [1:0]         gnt;
    logic               accept;
    logic               sel;
    logic [2:0]         sel_f3;
    logic [XLEN-1:0]    sel_a;
    logic [XLEN-1:0]    sel_b;
    logic [4:0]         sel_rd;

    logic               a_sgn;
    logic               b_sgn;
    logic               a_neg;
    logic               b_neg;
    logic [XLEN-1:0]    a_mag;
    logic [XLEN-1:0]    b_mag;
    logic               neg_init;
    logic               fast;
    logic [XLEN-1:0]    fast_data;

    logic [XLEN:0]      mul_sum;
    logic [XLEN:0]      div_shift;
    logic [XLEN:0]      div_diff;
    logic               div_ge;
    logic [2*XLEN-1:0]  step_next;

    // Sign fix-up of the magnitude result: product for multiplies,
    // quotient for DIV/DIVU, remainder for REM/REMU.
    function automatic logic [XLEN-1:0] form_result(input logic [2:0] f3,
                                                    input logic [2*XLEN-1:0] a,
                                                    input logic n);
        logic [2*XLEN-1:0] prod;
        logic [XLEN-1:0]   quo;
        logic [XLEN-1:0]   rem;
        prod = n ? -a : a;
        quo  = n ? -a[XLEN-1:0] : a[XLEN-1:0];
        rem  = n ? -a[2*XLEN-1:XLEN] : a[2*XLEN-1:XLEN];
        if (!is_div(f3)) begin
            return (f3 == F3_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
        end
        return f3[1] ? rem : quo;
    endfunction

    assign en = (state == IDLE) && !flush_i && reset_n;

    rr_arbiter2 u_arb (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (en),
        .req     ({bus.req_valid_1, bus.req_valid_0}),
        .gnt     (gnt)
    );

    assign bus.req_ready_0 = gnt[0];
    assign bus.req_ready_1 = gnt[1];
    assign accept          = |gnt;
    assign sel             = gnt[1];

    assign sel_f3 = sel ? bus.req_funct3_1 : bus.req_funct3_0;
    assign sel_a  = sel ? bus.req_a_1      : bus.req_a_0;
    assign sel_b  = sel ? bus.req_b_1      : bus.req_b_0;
    assign sel_rd = sel ? bus.req_rd_1     : bus.req_rd_0;

    always_comb begin
        a_sgn = 1'b0;
        b_sgn = 1'b0;
        case (sel_f3)
            F3_MUL, F3_MULH, F3_DIV, F3_REM: begin
                a_sgn = 1'b1;
                b_sgn = 1'b1;
            end
            F3_MULHSU: a_sgn = 1'b1;
            default: begin
                a_sgn = 1'b0;
                b_sgn = 1'b0;
            end
        endcase
    end

    assign a_neg    = a_sgn & sel_a[XLEN-1];
    assign b_neg    = b_sgn & sel_b[XLEN-1];
    assign a_mag    = a_neg ? -sel_a : sel_a;
    assign b_mag    = b_neg ? -sel_b : sel_b;
    assign neg_init = (sel_f3 == F3_REM) ? a_neg : (a_neg ^ b_neg);

    // Divide-by-zero and INT_MIN/-1 resolve without iterating.
    always_comb begin
        fast      = 1'b0;
        fast_data = '0;
        if (is_div(sel_f3)) begin
            if (sel_b == '0) begin
                fast      = 1'b1;
                fast_data = sel_f3[1] ? sel_a : '1;
            end else if (!sel_f3[0] && (sel_a == INT_MIN) && (sel_b == '1)) begin
                fast      = 1'b1;
                fast_data = sel_f3[1] ? '0 : INT_MIN;
            end
        end
    end

    // Multiply: acc = {partial product, remaining multiplier}, opb = multiplicand.
    // Divide:   acc = {partial remainder, dividend/quotient}, opb = divisor.
    assign mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opb} : '0);
    assign div_shift = acc[2*XLEN-1:XLEN-1];
    assign div_diff  = div_shift - {1'b0, opb};
    assign div_ge    = !div_diff[XLEN];

    always_comb begin
        if (is_div(op_f3)) begin
            step_next = {(div_ge ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0]),
                         acc[XLEN-2:0], div_ge};
        end else begin
            step_next = {mul_sum, acc[XLEN-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            op_f3 <= sel_f3;
            acc   <= {{XLEN{1'b0}}, (is_div(sel_f3) ? a_mag : b_mag)};
            opb   <= is_div(sel_f3) ? b_mag : a_mag;
            neg   <= neg_init;
        end else if (state == BUSY) begin
            acc   <= step_next;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            count          <= '0;
            bus.resp_data  <= '0;
            bus.resp_rd    <= '0;
            bus.resp_lane  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        bus.resp_rd   <= sel_rd;
                        bus.resp_lane <= sel;
                        count         <= '0;
                        if (fast) begin
                            bus.resp_data <= fast_data;
                            state         <= DONE;
                        end else begin
                            state         <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    if (flush_i) begin
                        state <= IDLE;
                        count <= '0;
                    end else if (count == CNT_W'(ITER - 1)) begin
                        bus.resp_data <= form_result(op_f3, step_next, neg);
                        count         <= '0;
                        state         <= DONE;
                    end else begin
                        count <= count + CNT_W'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                    count <= '0;
                end
                default: begin
                    state <= IDLE;
                    count <= '0;
                end
            endcase
        end
    end

    assign bus.resp_valid = (state == DONE) && !flush_i;
    assign busy_o         = (state != IDLE);

endmodule

// File: tb/tb_ex_muldiv_sched.sv
// Directed bench for ex_muldiv_sched: arbitration, latency, M-op results,
// divide fast paths, flush and asynchronous reset.
module tb_ex_muldiv_sched;
    import ex_muldiv_pkg::*;

    logic clk = 1'b0;
    logic reset_n;
    logic flush;
    logic busy;
    int   n_chk  = 0;
    int   n_pass = 0;
    int   pulses;

    ex_muldiv_sched_if #(.XLEN(32)) bus ();

    ex_muldiv_sched #(.XLEN(32), .ITER(32)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .flush_i (flush),
        .busy_o  (busy),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input bit lane, input bit v, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
        if (!lane) begin
            bus.req_valid_0 = v; bus.req_funct3_0 = f3;
            bus.req_a_0 = a; bus.req_b_0 = b; bus.req_rd_0 = rd;
        end else begin
            bus.req_valid_1 = v; bus.req_funct3_1 = f3;
            bus.req_a_1 = a; bus.req_b_1 = b; bus.req_rd_1 = rd;
        end
    endtask

    task automatic drop(input bit lane);
        if (!lane) bus.req_valid_0 = 1'b0;
        else       bus.req_valid_1 = 1'b0;
    endtask

    // Entered at the negedge right after the accept edge.
    task automatic finish_resp(input string tag, input int exp_lat, input logic [31:0] exp_data,
                               input bit exp_lane, input logic [4:0] exp_rd);
        int lat;
        lat = 0;
        while (bus.resp_valid !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, ".lat"},   32'(lat),       32'(exp_lat));
        chk({tag, ".valid"}, bus.resp_valid, 32'd1);
        chk({tag, ".data"},  bus.resp_data,  exp_data);
        chk({tag, ".lane"},  bus.resp_lane,  32'(exp_lane));
        chk({tag, ".rd"},    bus.resp_rd,    32'(exp_rd));
        @(negedge clk);
        chk({tag, ".pulse"}, bus.resp_valid, 32'd0);
        chk({tag, ".idle"},  busy,           32'd0);
    endtask

    task automatic op1(input string tag, input bit lane, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd,
                       input logic [31:0] exp_data, input int exp_lat);
        set_req(lane, 1'b1, f3, a, b, rd);
        #1;
        chk({tag, ".ready"}, lane ? bus.req_ready_1 : bus.req_ready_0, 32'd1);
        @(negedge clk);
        drop(lane);
        finish_resp(tag, exp_lat, exp_data, lane, rd);
    endtask

    initial begin
        reset_n = 1'b0;
        flush   = 1'b0;
        set_req(1'b0, 1'b1, F3_MUL, 32'd0, 32'd0, 5'd0);
        set_req(1'b1, 1'b0, F3_MUL, 32'd0, 32'd0, 5'd0);
        @(negedge clk);
        @(negedge clk);
        chk("rst.busy",   busy,            32'd0);
        chk("rst.valid",  bus.resp_valid,  32'd0);
        chk("rst.data",   bus.resp_data,   32'd0);
        chk("rst.rd",     bus.resp_rd,     32'd0);
        chk("rst.lane",   bus.resp_lane,   32'd0);
        chk("rst.ready0", bus.req_ready_0, 32'd0);
        drop(1'b0);
        reset_n = 1'b1;
        @(negedge clk);

        // Basic multiply
        op1("mul7x6", 1'b0, F3_MUL, 32'd7, 32'd6, 5'd5, 32'd42, 32);

        // Contention: lane0 wins first, lane1 follows
        set_req(1'b0, 1'b1, F3_DIV,  32'hFFFF_FFEC, 32'd3, 5'd3);
        set_req(1'b1, 1'b1, F3_REMU, 32'd20,        32'd3, 5'd4);
        #1;
        chk("arb1.ready0", bus.req_ready_0, 32'd1);
        chk("arb1.ready1", bus.req_ready_1, 32'd0);
        @(negedge clk);
        drop(1'b0);
        chk("arb1.busy_ready1", bus.req_ready_1, 32'd0);
        finish_resp("div_m20_3", 32, 32'hFFFF_FFFA, 1'b0, 5'd3);
        #1;
        chk("arb2.ready1", bus.req_ready_1, 32'd1);
        @(negedge clk);
        drop(1'b1);
        finish_resp("remu20_3", 32, 32'd2, 1'b1, 5'd4);

        // Repeat contention: pointer now favours lane1
        set_req(1'b0, 1'b1, F3_REM,  32'd100, 32'd0, 5'd7);
        set_req(1'b1, 1'b1, F3_DIVU, 32'd9,   32'd0, 5'd8);
        #1;
        chk("arb3.ready0", bus.req_ready_0, 32'd0);
        chk("arb3.ready1", bus.req_ready_1, 32'd1);
        @(negedge clk);
        drop(1'b1);
        finish_resp("divu9_0", 0, 32'hFFFF_FFFF, 1'b1, 5'd8);
        #1;
        chk("arb4.ready0", bus.req_ready_0, 32'd1);
        @(negedge clk);
        drop(1'b0);
        finish_resp("rem100_0_l0", 0, 32'd100, 1'b0, 5'd7);

        // Divide fast paths and signed remainder
        op1("div100_0",   1'b0, F3_DIV, 32'd100,       32'd0,         5'd9,  32'hFFFF_FFFF, 0);
        op1("rem100_0",   1'b1, F3_REM, 32'd100,       32'd0,         5'd10, 32'd100,       0);
        op1("div_ovf",    1'b0, F3_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'h8000_0000, 0);
        op1("rem_ovf",    1'b0, F3_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'd0,         0);
        op1("rem_m7_2",   1'b1, F3_REM, 32'hFFFF_FFF9, 32'd2,         5'd13, 32'hFFFF_FFFF, 32);

        // Multiply-high variants
        op1("mulh",   1'b0, F3_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd14, 32'd0,         32);
        op1("mulhu",  1'b1, F3_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd15, 32'hFFFF_FFFE, 32);
        op1("mulhsu", 1'b0, F3_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd16, 32'hFFFF_FFFF, 32);
        op1("mul_min2", 1'b1, F3_MUL,  32'h8000_0000, 32'd2,         5'd17, 32'd0,         32);

        // Flush during BUSY at iteration 10
        set_req(1'b0, 1'b1, F3_MUL, 32'd7, 32'd6, 5'd18);
        #1;
        chk("fl.ready0", bus.req_ready_0, 32'd1);
        @(negedge clk);
        drop(1'b0);
        repeat (10) @(negedge clk);
        chk("fl.busy_before", busy, 32'd1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        #1;
        chk("fl.busy_after", busy, 32'd0);
        pulses = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.resp_valid === 1'b1) pulses++;
        end
        chk("fl.no_resp", 32'(pulses), 32'd0);

        // Flush in IDLE blocks the grant
        flush = 1'b1;
        set_req(1'b0, 1'b1, F3_MUL, 32'd3, 32'd4, 5'd19);
        #1;
        chk("fl_idle.ready0", bus.req_ready_0, 32'd0);
        @(negedge clk);
        chk("fl_idle.busy", busy, 32'd0);
        flush = 1'b0;
        op1("mul3x4", 1'b0, F3_MUL, 32'd3, 32'd4, 5'd19, 32'd12, 32);

        // Contended grant moves pointer to lane1, then async reset mid-BUSY
        set_req(1'b0, 1'b1, F3_MUL,  32'd5, 32'd5, 5'd20);
        set_req(1'b1, 1'b1, F3_DIVU, 32'd7, 32'd0, 5'd21);
        #1;
        chk("rs.ready0", bus.req_ready_0, 32'd1);
        @(negedge clk);
        drop(1'b0);
        repeat (5) @(negedge clk);
        chk("rs.busy_pre", busy, 32'd1);
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk("rs.busy",   busy,            32'd0);
        chk("rs.valid",  bus.resp_valid,  32'd0);
        chk("rs.ready0", bus.req_ready_0, 32'd0);
        chk("rs.ready1", bus.req_ready_1, 32'd0);
        chk("rs.data",   bus.resp_data,   32'd0);
        chk("rs.lane",   bus.resp_lane,   32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        set_req(1'b0, 1'b1, F3_DIVU, 32'd5, 32'd0, 5'd22);
        #1;
        chk("rs.ptr_ready0", bus.req_ready_0, 32'd1);
        chk("rs.ptr_ready1", bus.req_ready_1, 32'd0);
        @(negedge clk);
        drop(1'b0);
        finish_resp("rs_divu5_0", 0, 32'hFFFF_FFFF, 1'b0, 5'd22);
        #1;
        chk("rs.ready1_next", bus.req_ready_1, 32'd1);
        @(negedge clk);
        drop(1'b1);
        finish_resp("rs_divu7_0", 0, 32'hFFFF_FFFF, 1'b1, 5'd21);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/ex_muldiv_sched.md
Name: ex_muldiv_sched

Overview:
- Shared iterative RISC-V M-extension unit for the EX stage of the dual-issue pipeline.
- Arbitrates between the two issue lanes and sequences a single radix-2 shift-add multiplier / restoring divider.
- Returns one result, tagged with lane and rd, back to the EX/MEM boundary.
- The lane that is not granted is stalled by the hazard logic until it is accepted.

Parameters:
XLEN, 32, operand/result width
ITER, XLEN, iterations per non-fast-path operation

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
req_valid_0  in  1  lane 0 M-op request
req_funct3_0  in  3  lane 0 RISC-V M funct3
req_a_0  in  XLEN  lane 0 rs1 value (post-forwarding)
req_b_0  in  XLEN  lane 0 rs2 value (post-forwarding)
req_rd_0  in  5  lane 0 destination register
req_ready_0  out  1  lane 0 accepted this cycle
req_valid_1, req_funct3_1, req_a_1, req_b_1, req_rd_1, req_ready_1  same as lane 0, for lane 1
flush_i  in  1  kill in-flight op and block grant
busy_o  out  1  unit not IDLE
resp_valid  out  1  result valid, one-cycle pulse, no backpressure
resp_data  out  XLEN  result
resp_rd  out  5  destination register of result
resp_lane  out  1  lane that issued the op

Behaviour:
- Clock/reset: one clock, clk; reset is asynchronous and active-low on reset_n.
- Reset values: state IDLE, rr pointer lane 0, and busy_o, resp_valid, resp_data, resp_rd, resp_lane, req_ready_* all 0.
- funct3 encoding: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- States: IDLE, BUSY, DONE.
- Grant (combinational, IDLE only, and only when !flush_i):
  - One valid lane: grant that lane.
  - Both valid: grant the lane named by the rr pointer; the pointer then points to the other lane.
  - The pointer updates only on a grant.
- req_ready_x = grant_x. Handshake is valid && ready; the ungranted lane must hold its request stable.
- On the accept edge (E0), latch operands, funct3, rd and lane.
  - Divide fast paths go directly to DONE.
    - Divide by zero: DIV/DIVU → all-ones; REM/REMU → dividend.
    - Signed overflow (DIV/REM with a = 0x80000000, b = 0xFFFFFFFF): DIV → 0x80000000; REM → 0.
  - Otherwise go to BUSY with count = 0.
- BUSY: one iteration per cycle. After ITER iterations (edge E32), go to DONE.
  - Multiply: operands are converted to magnitude per signedness (MULH both signed, MULHSU rs1 only, MULHU none). A 2·XLEN product accumulates by shift-add. Negate at finish when the operand signs differ.
  - MUL returns product[XLEN-1:0]; the MULH* ops return product[2XLEN-1:XLEN].
  - Divide: restoring on magnitudes.
    - Quotient sign = sign(a) XOR sign(b), applied to DIV only.
    - Remainder takes the sign of the dividend (REM).
- DONE:
  - resp_valid = !flush_i for that cycle; resp_data, resp_rd, resp_lane are registered and stable.
  - Next edge goes to IDLE.
  - Latency: normal op, resp_valid in the cycle after E32. Fast path, resp_valid in the cycle after E0.
  - Throughput: one op per ITER+2 cycles (normal), 2 cycles (fast path).
- flush_i:
  - In BUSY or DONE: next state IDLE, no resp_valid, count cleared.
  - In IDLE: no grant that cycle; the rr pointer is unchanged.
- busy_o = (state != IDLE).
- reset_n low mid-operation: all outputs drop to reset values immediately (asynchronous); the op is lost.

Decomposition:
- Package ex_muldiv_pkg: funct3 localparams (F3_MUL..F3_REMU), state enum (IDLE/BUSY/DONE), XLEN default.
- One sub-module, rr_arbiter2: two requests plus enable in, one-hot grant out, registered pointer.
- The datapath and FSM stay in ex_muldiv_sched.

Test Plan:
1. Lane0 MUL a=7, b=6 → req_ready_0 = 1 at accept; resp_valid is a single pulse in the cycle after the 32nd post-accept edge; resp_data = 42, resp_lane = 0.
2. Both lanes valid in the same cycle, lane0 DIV −20/3 and lane1 REMU 20/3 → lane0 first, resp 0xFFFFFFFA (−6); lane1 granted next IDLE, resp 2. Repeat the simultaneous request → lane1 granted first.
3. DIV 100/0 → 0xFFFFFFFF; REM 100/0 → 100. Each has resp_valid in the cycle after accept.
4. DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM on the same operands → 0; fast path; REM −7/2 → 0xFFFFFFFF (−1).
5. Multiply-high ops:
   - MULH 0xFFFFFFFF×0xFFFFFFFF → 0.
   - MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE.
   - MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF.
   - MUL 0x80000000×2 → 0.
6. Flush and reset:
   - flush_i pulsed at BUSY iteration 10 → no resp_valid; busy_o = 0 next cycle; next request accepted.
   - reset_n low mid-BUSY → busy_o, resp_valid, req_ready_* = 0 without waiting for a clock edge; rr pointer = lane 0.
